vga_rx: RTL and testbench
=========================

VGA_RX -- requirements
Module: vga_rx

Interface
REQ-001 Parameter H_DISP, default 640, visible pixels per line.
REQ-002 Parameter H_TOTAL, default 800, pixel ticks per line.
REQ-003 Parameter H_POST, default 48, ticks from the hsync falling edge to the first visible pixel.
REQ-004 Parameter V_DISP, default 480, visible lines per frame; V_TOTAL, default 525, lines per frame; V_POST, default 10, lines from the vsync falling edge to the first visible line.
REQ-005 Port list; reset is synchronous and active-high:
  - clk  in  1  system clock
  - reset  in  1  synchronous reset
  - p_tick  in  1  pixel-rate enable
  - hsync  in  1  horizontal sync, active-high
  - vsync  in  1  vertical sync, active-high
  - rgb  in  3  pixel colour
  - pixel_x  out  10  recovered column
  - pixel_y  out  10  recovered row
  - pixel_valid  out  1  visible pixel strobe
  - rgb_out  out  3  captured colour
  - frame_start  out  1  one-clk pulse at the vsync falling edge
  - locked  out  1  timing lock
  - timing_err  out  1  sticky timing error

Function
REQ-006 On a p_tick cycle, hsync/vsync/rgb SHALL be registered into stage 1; all other logic SHALL advance only on p_tick cycles.
REQ-007 A falling edge is stage-1 sync = 0 with the previous stage-1 sync = 1.
REQ-008 h_cnt SHALL load 0 on an hsync falling edge and otherwise increment, saturating at 1023.
REQ-009 v_cnt SHALL load 0 on a vsync falling edge and otherwise increment on each hsync falling edge, saturating at 1023.
REQ-010 When vsync and hsync fall on the same tick, v_cnt SHALL load 0 (the vsync edge takes priority).
REQ-011 A pixel is visible when locked=1, H_POST <= h_cnt < H_POST+H_DISP, and V_POST <= v_cnt < V_POST+V_DISP.
REQ-012 For a visible pixel, on the next p_tick cycle: pixel_valid=1, pixel_x=h_cnt-H_POST, pixel_y=v_cnt-V_POST, rgb_out=the stage-1 rgb of that sample. Latency is exactly one p_tick from the stage-1 capture.
REQ-013 pixel_valid SHALL be high for one clk per visible pixel and low on all non-p_tick cycles; pixel_x, pixel_y and rgb_out SHALL hold between strobes.
REQ-014 frame_start SHALL pulse for one clk on every vsync falling edge, regardless of lock.
REQ-015 State machine states: SEARCH, ALIGN, LOCKED.
  - SEARCH -> ALIGN on a vsync falling edge.
  - ALIGN -> LOCKED on the next vsync falling edge if no timing error occurred in the frame; otherwise it stays in ALIGN.
  - LOCKED -> SEARCH on any timing error.
REQ-016 A timing error is either:
  - an hsync falling edge with h_cnt != H_TOTAL-1, except the first edge after SEARCH; or
  - a vsync falling edge with v_cnt != V_TOTAL-1 while in ALIGN or LOCKED.
REQ-017 locked SHALL equal (state == LOCKED).
REQ-018 timing_err SHALL set on any timing error in LOCKED and clear only on reset.

Reset
REQ-019 When reset=1 on a clk edge, the block SHALL take state SEARCH, h_cnt=0, v_cnt=0, all stage registers 0, and all outputs 0, independent of p_tick.
REQ-020 A reset asserted mid-frame SHALL discard the partial frame; the block relocks only through SEARCH and ALIGN.

Configuration
REQ-021 Macro VGA_RX_CHECK_EN:
  - Defined: REQ-015, REQ-016 and REQ-018 apply as written.
  - Undefined: SEARCH -> LOCKED on the first vsync falling edge, LOCKED is never left except by reset, and timing_err is tied 0.

Structure
REQ-022 A shared package vga_pkg SHALL hold the timing defaults (640/800/48, 480/525/10), the state encoding, and the 10-bit coordinate width.
REQ-023 One sub-module, vga_edge_det (registered sync plus falling-edge pulse, gated by p_tick), SHALL be instantiated once for hsync and once for vsync.

Verification
REQ-024 Feed the output of the team's vga_sync and vga_test with sw=3'b101 into this block -> locked=1 after the second vsync falling edge; then 307200 pixel_valid strobes per frame, all with rgb_out=3'b101.
REQ-025 Locked stream, inspect first and last visible pixels -> first strobe pixel_x=0, pixel_y=0; last strobe pixel_x=639, pixel_y=479.
REQ-026 Shorten one line to 799 ticks while locked -> locked falls on that hsync edge; timing_err=1 and stays 1 (check enabled).
REQ-027 Assert reset for one clk at line 200 -> next clk shows all outputs 0 and state SEARCH; relock at the second following vsync falling edge.
REQ-028 Apply hsync and vsync falling edges on the same tick -> v_cnt=0 and frame_start pulses exactly once.
REQ-029 Build with the macro undefined and send a 520-line frame -> locked stays 1 and timing_err stays 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing defaults, receiver state encoding and coordinate width for the VGA receive path.
package vga_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned RGB_W       = 3;

  localparam int unsigned H_DISP_DEF  = 640;
  localparam int unsigned H_TOTAL_DEF = 800;
  localparam int unsigned H_POST_DEF  = 48;
  localparam int unsigned V_DISP_DEF  = 480;
  localparam int unsigned V_TOTAL_DEF = 525;
  localparam int unsigned V_POST_DEF  = 10;

  localparam logic [COORD_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

  // Increment that sticks at the top of the coordinate range.
  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == CNT_MAX) ? v : v + COORD_W'(1);
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Stage-1 sync register plus falling-edge detect, both advancing only on pixel ticks.
module vga_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic p_tick,
  input  logic din,
  output logic fall_c
);

  logic level;

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= 1'b0;
    end else if (p_tick) begin
      level <= din;
    end
  end

  // High on the tick whose captured sample is 0 while the held sample is 1.
  assign fall_c = p_tick & level & ~din;

endmodule

// File: rtl/vga_rx.sv
// VGA timing receiver: recovers pixel coordinates from hsync/vsync and strobes visible pixels.
// Macro VGA_RX_CHECK_EN enables line/frame length checking, the ALIGN stage and sticky timing_err.
module vga_rx
  import vga_pkg::*;
#(
  parameter int unsigned H_DISP  = H_DISP_DEF,
  parameter int unsigned H_TOTAL = H_TOTAL_DEF,
  parameter int unsigned H_POST  = H_POST_DEF,
  parameter int unsigned V_DISP  = V_DISP_DEF,
  parameter int unsigned V_TOTAL = V_TOTAL_DEF,
  parameter int unsigned V_POST  = V_POST_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p_tick,
  input  logic               hsync,
  input  logic               vsync,
  input  logic [RGB_W-1:0]   rgb,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               pixel_valid,
  output logic [RGB_W-1:0]   rgb_out,
  output logic               frame_start,
  output logic               locked,
  output logic               timing_err
);

  localparam logic [COORD_W-1:0] H_LO = COORD_W'(H_POST);
  localparam logic [COORD_W-1:0] H_HI = COORD_W'(H_POST + H_DISP);
  localparam logic [COORD_W-1:0] V_LO = COORD_W'(V_POST);
  localparam logic [COORD_W-1:0] V_HI = COORD_W'(V_POST + V_DISP);
  // A window that does not fit inside the total never produces visible pixels.
  localparam bit TIMING_OK = (H_POST + H_DISP <= H_TOTAL) && (V_POST + V_DISP <= V_TOTAL);

  rx_state_t          state;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic [RGB_W-1:0]   rgb_s1;
  logic               h_fall_c;
  logic               v_fall_c;
  logic               visible_c;

  vga_edge_det u_hs (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick),
    .din    (hsync),
    .fall_c (h_fall_c)
  );

  vga_edge_det u_vs (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick),
    .din    (vsync),
    .fall_c (v_fall_c)
  );

  // Counters describe the sample currently held in stage 1.
  assign visible_c = TIMING_OK && (state == LOCKED) &&
                     (h_cnt >= H_LO) && (h_cnt < H_HI) &&
                     (v_cnt >= V_LO) && (v_cnt < V_HI);

`ifdef VGA_RX_CHECK_EN
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  logic h_seen;
  logic frame_err;
  logic err_c;

  // The first hsync edge after SEARCH only establishes the line phase.
  assign err_c = (h_fall_c & h_seen & (h_cnt != H_LAST)) |
                 (v_fall_c & (state != SEARCH) & (v_cnt != V_LAST));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEARCH;
      h_cnt       <= '0;
      v_cnt       <= '0;
      rgb_s1      <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      rgb_out     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
`ifdef VGA_RX_CHECK_EN
      h_seen      <= 1'b0;
      frame_err   <= 1'b0;
`endif
    end else begin
      pixel_valid <= 1'b0;
      frame_start <= v_fall_c;
      if (p_tick) begin
        rgb_s1 <= rgb;
        h_cnt  <= h_fall_c ? '0 : sat_inc(h_cnt);
        if (v_fall_c) begin
          v_cnt <= '0;
        end else if (h_fall_c) begin
          v_cnt <= sat_inc(v_cnt);
        end

        if (visible_c) begin
          pixel_valid <= 1'b1;
          pixel_x     <= h_cnt - H_LO;
          pixel_y     <= v_cnt - V_LO;
          rgb_out     <= rgb_s1;
        end

`ifdef VGA_RX_CHECK_EN
        if (h_fall_c) begin
          h_seen <= 1'b1;
        end
        case (state)
          SEARCH: begin
            if (v_fall_c) begin
              state     <= ALIGN;
              frame_err <= 1'b0;
            end
          end
          ALIGN: begin
            if (v_fall_c) begin
              frame_err <= 1'b0;
              if (!(frame_err | err_c)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else if (err_c) begin
              frame_err <= 1'b1;
            end
          end
          LOCKED: begin
            if (err_c) begin
              state      <= SEARCH;
              locked     <= 1'b0;
              timing_err <= 1'b1;
              h_seen     <= 1'b0;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
`else
        if ((state == SEARCH) && v_fall_c) begin
          state  <= LOCKED;
          locked <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_vga_rx.sv
// Self-checking bench for vga_rx: scaled-down timing, per-clock reference model plus frame-level table.
module tb_vga_rx;

  localparam int unsigned HD = 6;
  localparam int unsigned HT = 12;
  localparam int unsigned HP = 3;
  localparam int unsigned VD = 4;
  localparam int unsigned VT = 7;
  localparam int unsigned VP = 2;
  localparam int FULL = HD * VD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       p_tick = 1'b0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic [2:0] rgb = 3'd0;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       pixel_valid;
  logic [2:0] rgb_out;
  logic       frame_start;
  logic       locked;
  logic       timing_err;

  vga_rx #(
    .H_DISP(HD), .H_TOTAL(HT), .H_POST(HP),
    .V_DISP(VD), .V_TOTAL(VT), .V_POST(VP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .p_tick      (p_tick),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_valid (pixel_valid),
    .rgb_out     (rgb_out),
    .frame_start (frame_start),
    .locked      (locked),
    .timing_err  (timing_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at t=%0t", name, act, act, want, want, $time);
    end
  endtask

  // Reference model: tracks line/frame position from the rules, not from DUT internals.
  int   m_h, m_v;
  bit   m_prev_hs, m_prev_vs, m_locked;
  logic [2:0] m_prev_rgb;
`ifdef VGA_RX_CHECK_EN
  bit   m_aligned, m_seen, m_ferr;
`endif
  logic       e_valid, e_fs, e_locked, e_err;
  logic [9:0] e_x, e_y;
  logic [2:0] e_rgb;

  task automatic model_step();
    bit hf, vf;
`ifdef VGA_RX_CHECK_EN
    bit err;
`endif
    if (reset) begin
      m_h = 0; m_v = 0; m_prev_hs = 0; m_prev_vs = 0; m_prev_rgb = 3'd0; m_locked = 0;
`ifdef VGA_RX_CHECK_EN
      m_aligned = 0; m_seen = 0; m_ferr = 0;
`endif
      e_valid = 0; e_fs = 0; e_locked = 0; e_err = 0; e_x = 10'd0; e_y = 10'd0; e_rgb = 3'd0;
      return;
    end
    e_valid = 0;
    e_fs = 0;
    if (!p_tick) return;
    hf = m_prev_hs && !hsync;
    vf = m_prev_vs && !vsync;
    if (m_locked && m_h >= HP && m_h < HP + HD && m_v >= VP && m_v < VP + VD) begin
      e_valid = 1;
      e_x = 10'(m_h - HP);
      e_y = 10'(m_v - VP);
      e_rgb = m_prev_rgb;
    end
    e_fs = vf;
`ifdef VGA_RX_CHECK_EN
    err = (hf && m_seen && m_h != HT - 1) || (vf && (m_aligned || m_locked) && m_v != VT - 1);
`endif
    m_h = hf ? 0 : (m_h < 1023 ? m_h + 1 : 1023);
    if (vf) m_v = 0;
    else if (hf) m_v = (m_v < 1023) ? m_v + 1 : 1023;
`ifdef VGA_RX_CHECK_EN
    if (hf) m_seen = 1;
    if (m_locked) begin
      if (err) begin m_locked = 0; m_aligned = 0; m_seen = 0; e_err = 1; end
    end else if (m_aligned) begin
      if (err) m_ferr = 1;
      if (vf) begin
        if (!m_ferr) begin m_locked = 1; m_aligned = 0; end
        m_ferr = 0;
      end
    end else if (vf) begin
      m_aligned = 1;
      m_ferr = 0;
    end
`else
    if (vf) m_locked = 1;
`endif
    m_prev_hs = hsync;
    m_prev_vs = vsync;
    m_prev_rgb = rgb;
    e_locked = m_locked;
  endtask

  // Frame scoreboard fed from the DUT strobes.
  int sb_cnt = 0, fs_cnt = 0;
  logic [9:0] sb_fx, sb_fy, sb_lx, sb_ly;

  always @(posedge clk) begin
    model_step();
    if (reset) chk_on = 1'b1;
    #1;
    if (chk_on) begin
      tests++;
      if ({pixel_valid, pixel_x, pixel_y, rgb_out, frame_start, locked, timing_err} !==
          {e_valid, e_x, e_y, e_rgb, e_fs, e_locked, e_err}) begin
        fails++;
        $display("FAIL clk_outputs t=%0t valid/x/y/rgb/fs/lock/err got %b/%0d/%0d/%0d/%b/%b/%b expected %b/%0d/%0d/%0d/%b/%b/%b",
                 $time, pixel_valid, pixel_x, pixel_y, rgb_out, frame_start, locked, timing_err,
                 e_valid, e_x, e_y, e_rgb, e_fs, e_locked, e_err);
      end
    end
    if (frame_start === 1'b1) begin fs_cnt++; sb_cnt = 0; end
    if (pixel_valid === 1'b1) begin
      if (sb_cnt == 0) begin sb_fx = pixel_x; sb_fy = pixel_y; end
      sb_lx = pixel_x; sb_ly = pixel_y;
      sb_cnt++;
    end
  end

  // One pixel tick followed by 0..2 idle clocks carrying junk on the inputs.
  task automatic tick(input logic hs, input logic vs);
    int n;
    p_tick = 1'b1; hsync = hs; vsync = vs; rgb = 3'($urandom);
    @(negedge clk);
    p_tick = 1'b0; hsync = 1'($urandom); vsync = 1'($urandom); rgb = 3'($urandom);
    n = $urandom_range(0, 2);
    repeat (n) @(negedge clk);
  endtask

  // hsync is high for the last two ticks of a line, so it falls on tick 0 of the next line.
  task automatic send_line(input int len, input logic vs);
    for (int p = 0; p < len; p++) tick(p >= len - 2, vs);
  endtask

  // vsync is high on the last line, so it falls together with hsync at the next frame's start.
  task automatic send_frame(input int nlines, input int short_line, input int short_len);
    for (int l = 0; l < nlines; l++) send_line((l == short_line) ? short_len : HT, l == nlines - 1);
  endtask

  typedef struct {
    string name;
    int    nframes;
    int    nlines;
    int    short_line;
    int    short_len;
    bit    exp_locked;
    bit    exp_err;
    int    exp_strobes;
  } row_t;

  row_t rows[8];

  function automatic row_t mk(input string n, input int nf, input int nl, input int sl, input int slen,
                              input bit lk, input bit er, input int st);
    row_t r;
    r.name = n; r.nframes = nf; r.nlines = nl; r.short_line = sl; r.short_len = slen;
    r.exp_locked = lk; r.exp_err = er; r.exp_strobes = st;
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs0;
`ifdef VGA_RX_CHECK_EN
    rows[0] = mk("search_to_align",   1, VT,     -1, HT,     1'b0, 1'b0, 0);
    rows[1] = mk("align_to_lock",     1, VT,     -1, HT,     1'b1, 1'b0, FULL);
    rows[2] = mk("locked_stream",     2, VT,     -1, HT,     1'b1, 1'b0, FULL);
    rows[3] = mk("short_line",        1, VT,      3, HT - 1, 1'b0, 1'b1, 2 * HD);
    rows[4] = mk("resync_search",     1, VT,     -1, HT,     1'b0, 1'b1, 0);
    rows[5] = mk("relock",            1, VT,     -1, HT,     1'b1, 1'b1, FULL);
    rows[6] = mk("short_frame",       1, VT - 1, -1, HT,     1'b1, 1'b1, FULL);
    rows[7] = mk("after_short_frame", 1, VT,     -1, HT,     1'b0, 1'b1, 0);
`else
    rows[0] = mk("first_vs_lock",     1, VT,     -1, HT,     1'b1, 1'b0, FULL);
    rows[1] = mk("stay_locked",       1, VT,     -1, HT,     1'b1, 1'b0, FULL);
    rows[2] = mk("locked_stream",     2, VT,     -1, HT,     1'b1, 1'b0, FULL);
    rows[3] = mk("short_line",        1, VT,      3, HT - 1, 1'b1, 1'b0, FULL);
    rows[4] = mk("after_short_line",  1, VT,     -1, HT,     1'b1, 1'b0, FULL);
    rows[5] = mk("steady",            1, VT,     -1, HT,     1'b1, 1'b0, FULL);
    rows[6] = mk("short_frame",       1, VT - 1, -1, HT,     1'b1, 1'b0, FULL);
    rows[7] = mk("after_short_frame", 1, VT,     -1, HT,     1'b1, 1'b0, FULL);
`endif

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_state", {pixel_valid, pixel_x, pixel_y, rgb_out, frame_start, locked, timing_err}, 32'd0);

    // Lead-in line with vsync high so the first table frame opens with a vsync edge.
    send_line(HT, 1'b1);

    for (int i = 0; i < 8; i++) begin
      fs0 = fs_cnt;
      for (int f = 0; f < rows[i].nframes; f++) send_frame(rows[i].nlines, rows[i].short_line, rows[i].short_len);
      check({rows[i].name, "_locked"}, 32'(locked), 32'(rows[i].exp_locked));
      check({rows[i].name, "_err"}, 32'(timing_err), 32'(rows[i].exp_err));
      check({rows[i].name, "_strobes"}, 32'(sb_cnt), 32'(rows[i].exp_strobes));
      check({rows[i].name, "_frame_starts"}, 32'(fs_cnt - fs0), 32'(rows[i].nframes));
      if (rows[i].exp_strobes == FULL) begin
        check({rows[i].name, "_first_xy"}, {sb_fx, sb_fy}, 32'd0);
        check({rows[i].name, "_last_xy"}, {sb_lx, sb_ly}, {10'(HD - 1), 10'(VD - 1)});
      end
    end

    // Reset pulse in the middle of line 3, coinciding with a pixel tick.
    for (int l = 0; l < 3; l++) send_line(HT, 1'b0);
    for (int p = 0; p < 5; p++) tick(p >= HT - 2, 1'b0);
    reset = 1'b1; p_tick = 1'b1; hsync = 1'b1; vsync = 1'b0;
    @(negedge clk);
    reset = 1'b0; p_tick = 1'b0;
    check("mid_reset_outputs", {pixel_valid, pixel_x, pixel_y, rgb_out, frame_start, locked, timing_err}, 32'd0);
    for (int p = 5; p < HT; p++) tick(p >= HT - 2, 1'b0);
    for (int l = 4; l < VT; l++) send_line(HT, l == VT - 1);
    send_frame(VT, -1, HT);
`ifdef VGA_RX_CHECK_EN
    check("relock_first_vs", 32'(locked), 32'd0);
`else
    check("relock_first_vs", 32'(locked), 32'd1);
`endif
    send_frame(VT, -1, HT);
    check("relock_second_vs", 32'(locked), 32'd1);
    check("relock_strobes", 32'(sb_cnt), 32'(FULL));
    check("relock_err_clear", 32'(timing_err), 32'd0);

    // Overlong line: the column counter saturates instead of wrapping into the window.
    sb_cnt = 0;
    send_line(1100, 1'b0);
    check("long_line_no_strobes", 32'(sb_cnt), 32'd0);
    send_line(HT, 1'b1);
    send_frame(VT, -1, HT);
`ifdef VGA_RX_CHECK_EN
    check("long_line_locked", 32'(locked), 32'd0);
    check("long_line_err", 32'(timing_err), 32'd1);
`else
    check("long_line_locked", 32'(locked), 32'd1);
    check("long_line_err", 32'(timing_err), 32'd0);
`endif

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
